// File: rtl/alu_md.sv
// alu_md: single-cycle ALU with multi-cycle MUL/DIV and HI/LO result registers
// Ports: iClk/iReset clock and synchronous active-high reset; iValid/oReady accept handshake;
//   iA/iB operands, iALUFun opcode, iSign signedness; oValid one-cycle pulse qualifying
//   the registered result oS and flags oZ (zero), oV (overflow), oN (negative), oDZ (divide-by-zero).
module alu_md #(
   parameter int WIDTH = 32,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic [5:0]       iALUFun,
   input  logic             iSign,
   output logic             oValid,
   output logic [WIDTH-1:0] oS,
   output logic             oZ,
   output logic             oV,
   output logic             oN,
   output logic             oDZ
);
   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b011000, OR = 6'b011110;
   localparam logic [5:0] XOR = 6'b010110, NOR = 6'b010001, STA = 6'b011010, SLL = 6'b100000;
   localparam logic [5:0] SRL = 6'b100001, SRA = 6'b100011, EQ = 6'b110011, NEQ = 6'b110001;
   localparam logic [5:0] LT = 6'b110101, LEZ = 6'b111101, GEZ = 6'b111001, GTZ = 6'b111111;
   localparam logic [5:0] LUI = 6'b011011, MUL = 6'b000100, DIV = 6'b000101;
   localparam logic [5:0] MFHI = 6'b000110, MFLO = 6'b000111;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_nx;

   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   hi_r, lo_r, a_q, b_q, acc_lo, res, mag_a, mag_b, fix_hi, fix_lo;
   logic [WIDTH:0]     acc_hi, add_x, sub_x, mul_sum, div_t, div_d;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic               res_v, is_md, accept, sgn_a, sgn_b;
   logic               sign_q, div_q, neg_q, rneg_q, dz_q, ovf_q;

   assign oReady = state == IDLE;
   assign accept = iValid && oReady;
   assign is_md  = iALUFun == MUL || iALUFun == DIV;

   always_ff @(posedge iClk)
      if (iReset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept && is_md ? CALC : IDLE;
         CALC:    state_nx = cnt == SHW'(WIDTH - 1) ? FIX : CALC;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      add_x = {1'b0, iA} + {1'b0, iB};
      sub_x = {1'b0, iA} - {1'b0, iB};
      res   = '0;
      res_v = 1'b0;
      case (iALUFun)
         ADD: begin
            res   = add_x[WIDTH-1:0];
            res_v = iSign ? iA[WIDTH-1] == iB[WIDTH-1] && add_x[WIDTH-1] != iA[WIDTH-1] : add_x[WIDTH];
         end
         SUB: begin
            res   = sub_x[WIDTH-1:0];
            res_v = iSign ? iA[WIDTH-1] != iB[WIDTH-1] && sub_x[WIDTH-1] != iA[WIDTH-1] : sub_x[WIDTH];
         end
         AND:  res = iA & iB;
         OR:   res = iA | iB;
         XOR:  res = iA ^ iB;
         NOR:  res = ~(iA | iB);
         STA:  res = iA;
         SLL:  res = iB << iA[SHW-1:0];
         SRL:  res = iB >> iA[SHW-1:0];
         SRA:  res = $signed(iB) >>> iA[SHW-1:0];
         EQ:   res = {{(WIDTH-1){1'b0}}, iA == iB};
         NEQ:  res = {{(WIDTH-1){1'b0}}, iA != iB};
         LT:   res = {{(WIDTH-1){1'b0}}, iSign ? $signed(iA) < $signed(iB) : iA < iB};
         LEZ:  res = {{(WIDTH-1){1'b0}}, iA[WIDTH-1] | ~|iA};
         GEZ:  res = {{(WIDTH-1){1'b0}}, ~iA[WIDTH-1]};
         GTZ:  res = {{(WIDTH-1){1'b0}}, ~iA[WIDTH-1] & |iA};
         LUI:  res = {iB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         MFHI: res = hi_r;
         MFLO: res = lo_r;
         default: res = '0;
      endcase
   end

   // Iteration runs on magnitudes; signs are reapplied in FIX.
   assign sgn_a   = iSign & iA[WIDTH-1];
   assign sgn_b   = iSign & iB[WIDTH-1];
   assign mag_a   = sgn_a ? -iA : iA;
   assign mag_b   = sgn_b ? -iB : iB;
   assign mul_sum = acc_hi + (acc_lo[0] ? {1'b0, b_q} : '0);
   assign div_t   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
   assign div_d   = div_t - {1'b0, b_q};
   assign prod    = {acc_hi[WIDTH-1:0], acc_lo};
   assign prod_s  = neg_q ? -prod : prod;
   assign fix_lo  = dz_q ? '1 : div_q ? (neg_q ? -acc_lo : acc_lo) : prod_s[WIDTH-1:0];
   assign fix_hi  = dz_q ? a_q : div_q ? (rneg_q ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0]) : prod_s[2*WIDTH-1:WIDTH];

   always_ff @(posedge iClk)
      if (iReset) begin
         cnt    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         oS     <= '0;
         oZ     <= 1'b1;
         oV     <= 1'b0;
         oN     <= 1'b0;
         oDZ    <= 1'b0;
         oValid <= 1'b0;
      end else begin
         oValid <= 1'b0;
         if (accept && is_md) begin
            acc_hi <= '0;
            acc_lo <= mag_a;
            b_q    <= mag_b;
            a_q    <= iA;
            cnt    <= '0;
            sign_q <= iSign;
            div_q  <= iALUFun == DIV;
            neg_q  <= sgn_a ^ sgn_b;
            rneg_q <= sgn_a;
            dz_q   <= iALUFun == DIV && iB == '0;
            ovf_q  <= iALUFun == DIV && iSign && iA == {1'b1, {(WIDTH-1){1'b0}}} && iB == '1;
         end else if (accept) begin
            oValid <= 1'b1;
            oS     <= res;
            oZ     <= res == '0;
            oV     <= res_v;
            oN     <= iSign & res[WIDTH-1];
            oDZ    <= 1'b0;
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
               acc_hi <= div_d[WIDTH] ? div_t : div_d;
               acc_lo <= {acc_lo[WIDTH-2:0], ~div_d[WIDTH]};
            end else begin
               acc_hi <= {1'b0, mul_sum[WIDTH:1]};
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end else if (state == FIX) begin
            hi_r   <= fix_hi;
            lo_r   <= fix_lo;
            oS     <= fix_lo;
            oZ     <= fix_lo == '0;
            oV     <= ovf_q;
            oN     <= sign_q & fix_lo[WIDTH-1];
            oDZ    <= dz_q;
            oValid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: randomized and directed bench for alu_md against an arithmetic reference model
module tb_alu_md;
   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, SLL = 6'b100000, LUI = 6'b011011;
   localparam logic [5:0] MUL = 6'b000100, DIV = 6'b000101, MFHI = 6'b000110, MFLO = 6'b000111;

   logic        iClk, iReset, iValid, iSign;
   logic [31:0] iA, iB;
   logic [5:0]  iALUFun;
   logic        oReady, oValid, oZ, oV, oN, oDZ;
   logic [31:0] oS;
   logic [31:0] hi_m, lo_m;
   int          n_tests, n_fail;

   logic [5:0] ops [22] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                            6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                            6'b110101, 6'b111101, 6'b111001, 6'b111111, 6'b011011, 6'b000110,
                            6'b000111, 6'b001111, 6'b101010, 6'b111000};

   alu_md dut (
      .iClk(iClk), .iReset(iReset), .iValid(iValid), .oReady(oReady), .iA(iA), .iB(iB),
      .iALUFun(iALUFun), .iSign(iSign), .oValid(oValid), .oS(oS), .oZ(oZ), .oV(oV),
      .oN(oN), .oDZ(oDZ)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rnd();
      logic [31:0] e [4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      return ($urandom_range(3) == 0) ? e[$urandom_range(3)] : $urandom();
   endfunction

   task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, output logic [31:0] s, output logic v);
      longint sa, sb, ua, ub, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      s = 0;
      v = 0;
      case (op)
         6'b000000: begin s = a + b; r = sg ? sa + sb : ua + ub; v = sg ? r != longint'($signed(s)) : r != longint'(s); end
         6'b000001: begin s = a - b; r = sg ? sa - sb : ua - ub; v = sg ? r != longint'($signed(s)) : r != longint'(s); end
         6'b011000: s = a & b;
         6'b011110: s = a | b;
         6'b010110: s = a ^ b;
         6'b010001: s = ~(a | b);
         6'b011010: s = a;
         6'b100000: s = b << a[4:0];
         6'b100001: s = b >> a[4:0];
         6'b100011: s = 32'(sb >>> a[4:0]);
         6'b110011: s = (a == b) ? 1 : 0;
         6'b110001: s = (a != b) ? 1 : 0;
         6'b110101: s = (sg ? sa < sb : ua < ub) ? 1 : 0;
         6'b111101: s = (sa <= 0) ? 1 : 0;
         6'b111001: s = (sa >= 0) ? 1 : 0;
         6'b111111: s = (sa > 0) ? 1 : 0;
         6'b011011: s = {b[15:0], 16'h0};
         6'b000110: s = hi_m;
         6'b000111: s = lo_m;
         default:   s = 0;
      endcase
   endtask

   task automatic single(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic sg);
      logic [31:0] s;
      logic        v;
      string       t;
      model(op, a, b, sg, s, v);
      t = $sformatf("op%b", op);
      iALUFun = op; iA = a; iB = b; iSign = sg; iValid = 1'b1;
      @(posedge iClk); #1;
      iValid = 1'b0;
      check({t, "_valid"}, oValid, 1);
      check({t, "_s"}, oS, s);
      check({t, "_z"}, oZ, s == 0);
      check({t, "_v"}, oV, v);
      check({t, "_n"}, oN, sg & s[31]);
      check({t, "_dz"}, oDZ, 0);
   endtask

   task automatic md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic sg);
      logic [63:0] p;
      logic [31:0] hi, lo;
      logic        v, dz;
      longint      sa, sb, ua, ub;
      int          n, busy_bad;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      v = 0;
      dz = 0;
      if (op == MUL) begin
         p = sg ? sa * sb : ua * ub;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 0) begin
         lo = '1; hi = a; dz = 1;
      end else if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         lo = a; hi = 0; v = 1;
      end else begin
         lo = 32'(sg ? sa / sb : ua / ub);
         hi = 32'(sg ? sa % sb : ua % ub);
      end
      iALUFun = op; iA = a; iB = b; iSign = sg; iValid = 1'b1;
      @(posedge iClk); #1;
      iALUFun = ADD; iA = $urandom(); iB = $urandom();
      n = 1;
      busy_bad = 0;
      while (!oValid && n < 60) begin
         if (oReady !== 1'b0) busy_bad++;
         if (n == 20) iValid = 1'b0;
         @(posedge iClk); #1;
         n++;
      end
      iValid = 1'b0;
      check("md_latency", n, 34);
      check("md_busy", busy_bad, 0);
      check("md_ready", oReady, 1);
      check("md_s", oS, lo);
      check("md_z", oZ, lo == 0);
      check("md_v", oV, v);
      check("md_n", oN, sg & lo[31]);
      check("md_dz", oDZ, dz);
      hi_m = hi;
      lo_m = lo;
      single(MFHI, $urandom(), $urandom(), sg);
      single(MFLO, $urandom(), $urandom(), sg);
   endtask

   initial begin
      int pulses;
      n_tests = 0; n_fail = 0;
      iReset = 1'b1; iValid = 1'b1; iALUFun = ADD; iA = 1; iB = 1; iSign = 0;
      @(posedge iClk); #1;
      @(posedge iClk); #1;
      iReset = 1'b0; iValid = 1'b0;
      hi_m = 0; lo_m = 0;
      check("rst_valid", oValid, 0);
      check("rst_ready", oReady, 1);
      check("rst_s", oS, 0);
      check("rst_z", oZ, 1);
      check("rst_v", oV, 0);
      check("rst_n", oN, 0);
      check("rst_dz", oDZ, 0);
      @(posedge iClk); #1;
      check("rst_drop", oValid, 0);
      single(MFLO, 0, 0, 0);

      single(ADD, 32'h7FFFFFFF, 1, 1);
      single(ADD, 32'h7FFFFFFF, 1, 0);
      single(SUB, 5, 5, 0);
      single(SLL, 4, 1, 0);
      single(LUI, 0, 32'h1234, 0);
      @(posedge iClk); #1;
      check("hold_valid", oValid, 0);
      check("hold_s", oS, 32'h12340000);

      md(MUL, -3, 5, 1);
      md(DIV, -7, 2, 1);
      md(DIV, 7, 0, 0);
      md(DIV, 32'h80000000, 32'hFFFFFFFF, 1);

      for (int i = 0; i < 80; i++) single(ops[$urandom_range(21)], rnd(), rnd(), 1'($urandom_range(1)));
      for (int i = 0; i < 10; i++) md($urandom_range(1) ? MUL : DIV, rnd(), ($urandom_range(4) == 0) ? 0 : rnd(), 1'($urandom_range(1)));

      md(MUL, 32'h12345, 32'h6789A, 0);
      iALUFun = MUL; iA = 3; iB = 5; iSign = 0; iValid = 1'b1;
      @(posedge iClk); #1;
      iValid = 1'b0;
      repeat (9) @(posedge iClk);
      #1;
      iReset = 1'b1;
      @(posedge iClk); #1;
      iReset = 1'b0;
      hi_m = 0; lo_m = 0;
      check("abort_valid", oValid, 0);
      check("abort_ready", oReady, 1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge iClk); #1;
         if (oValid) pulses++;
      end
      check("abort_pulses", pulses, 0);
      single(MFLO, 0, 0, 0);
      single(MFHI, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; not overridden by users.
REQ-003 The block SHALL have port iClk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iReset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port iValid, input, 1, an operation is presented this cycle.
REQ-006 The block SHALL have port oReady, output, 1, the block can accept an operation this cycle.
REQ-007 The block SHALL have ports iA and iB, input, WIDTH, operands.
REQ-008 The block SHALL have port iALUFun, input, 6, operation code.
REQ-009 The block SHALL have port iSign, input, 1, signed (1) or unsigned (0) interpretation.
REQ-010 The block SHALL have port oValid, output, 1, a one-cycle pulse that qualifies oS/oZ/oV/oN/oDZ.
REQ-011 The block SHALL have port oS, output, WIDTH, registered result.
REQ-012 The block SHALL have ports oZ, oV, oN and oDZ, output, 1 each: zero, overflow, negative, divide-by-zero.

Function
REQ-013 Opcodes SHALL be: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, STA 011010 (pass A), SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111, LUI 011011.
REQ-014 New opcodes SHALL be: MUL 000100, DIV 000101, MFHI 000110, MFLO 000111.
REQ-015 Any other opcode SHALL complete in 1 cycle with oS=0, oV=0 and oDZ=0.
REQ-016 An operation SHALL be accepted on an edge where iValid=1 and oReady=1; iValid while oReady=0 SHALL be ignored, with no queuing.
REQ-017 Single-cycle ops (all except MUL/DIV) SHALL register their result on the accept edge: oValid=1 in cycle N+1; throughput one per cycle, oReady stays 1.
REQ-018 Shifts SHALL shift iB by iA[SHW-1:0]; SRA SHALL replicate iB[WIDTH-1].
REQ-019 LUI SHALL produce {iB[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-020 Compare ops SHALL return 1 or 0 in bit 0, zero-extended; LT SHALL use iSign; LEZ/GEZ/GTZ SHALL always treat iA as signed.
REQ-021 ADD/SUB oV SHALL be signed overflow when iSign=1, and carry-out/borrow when iSign=0; oV=0 for all other ops.
REQ-022 oZ SHALL equal (oS==0); oN SHALL equal iSign & oS[WIDTH-1], using iSign as latched at accept.
REQ-023 MUL/DIV SHALL be handled by an FSM with states IDLE, CALC and FIX.
REQ-024 On accept in IDLE, the FSM SHALL latch operand magnitudes (two's-complement absolute value when iSign=1) and result signs, clear the counter, and go to CALC; oReady=0 from cycle N+1.
REQ-025 CALC SHALL perform one shift-add (MUL) or one restoring-subtract (DIV) step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-026 FIX SHALL apply signs, write HI/LO and oS=LO, pulse oValid, and return to IDLE; oValid=1 and oReady=1 SHALL both be in cycle N+WIDTH+2 (N+34 at WIDTH=32).
REQ-027 MUL results SHALL be HI:LO = full 2*WIDTH-bit product.
REQ-028 DIV results SHALL be LO = quotient truncated toward zero and HI = remainder with the sign of the dividend.
REQ-029 DIV by iB=0 SHALL still take full latency, with LO = all ones, HI = iA and oDZ=1; oDZ=0 for all other results.
REQ-030 DIV signed most-negative/-1 SHALL give LO = most-negative, HI = 0 and oV=1.
REQ-031 MUL/DIV oV SHALL be 0 except as specified in REQ-030.
REQ-032 MFHI/MFLO SHALL return HI/LO in 1 cycle; one issued in the cycle of FIX-return SHALL see the new values.
REQ-033 oS and the flags SHALL hold their value between oValid pulses.

Reset
REQ-034 iReset=1 at an edge SHALL force state=IDLE, counter=0, HI=LO=0, oS=0, oZ=1, oV=0, oN=0, oDZ=0, oValid=0 and oReady=1 on the next cycle.
REQ-035 iReset SHALL take priority over accept.
REQ-036 Reset in CALC/FIX SHALL abort the operation with no oValid and no HI/LO update.
REQ-037 iValid in the reset cycle SHALL be dropped.

Verification
REQ-038 A bench SHALL cover: ADD iA=0x7FFFFFFF, iB=1, iSign=1 -> cycle N+1: oS=0x80000000, oV=1, oN=1, oZ=0; same with iSign=0 -> oV=0, oN=0.
REQ-039 A bench SHALL cover: back-to-back SUB 5-5, SLL iA=4 iB=1, LUI iB=0x1234 on consecutive cycles -> three oValid pulses: oS=0 with oZ=1, then 0x10, then 0x12340000.
REQ-040 A bench SHALL cover: MUL iSign=1, iA=-3, iB=5, then MFHI, MFLO -> oValid at N+34 with oS=0xFFFFFFF1, oReady=0 for cycles N+1..N+33, MFHI=0xFFFFFFFF, MFLO=0xFFFFFFF1.
REQ-041 A bench SHALL cover: DIV iSign=1, iA=-7, iB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV iA=7, iB=0 -> LO=0xFFFFFFFF, HI=7, oDZ=1 at N+34.
REQ-042 A bench SHALL cover: DIV iSign=1, iA=0x80000000, iB=-1 -> LO=0x80000000, HI=0, oV=1.
REQ-043 A bench SHALL cover: iReset pulsed at cycle N+10 of a MUL -> no oValid, oReady=1 next cycle, and a following MFLO returns 0.
